// File: rtl/frame_color_pkg.sv
// frame_color_pkg
//   Shared types and constants for the frame colour detector and any other
//   consumer of the RGB332 pixel classifier (e.g. the overlay/VGA path).
//   Contents: colour/class codes, detector FSM state enum, RGB332 field
//   positions and the per-channel classification thresholds.
package frame_color_pkg;

  typedef enum logic [1:0] {
    CLR_NONE  = 2'b00,
    CLR_RED   = 2'b01,
    CLR_GREEN = 2'b10,
    CLR_BLUE  = 2'b11
  } color_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DECIDE = 2'd3
  } state_e;

  // RGB332 layout: {R[7:5], G[4:2], B[1:0]}
  localparam int R_MSB = 7;
  localparam int R_LSB = 5;
  localparam int G_MSB = 4;
  localparam int G_LSB = 2;
  localparam int B_MSB = 1;
  localparam int B_LSB = 0;

  // A 3-bit channel is "strong" at >= 4 and "weak" at <= 3;
  // the 2-bit blue channel is strong at >= 2 and weak at <= 1.
  localparam logic [2:0] RG_HI_TH = 3'd4;
  localparam logic [2:0] RG_LO_TH = 3'd3;
  localparam logic [1:0] B_LO_TH  = 2'd1;
  localparam logic [1:0] B_HI_TH  = 2'd2;

endpackage

// File: rtl/px_classify.sv
// px_classify
//   Combinational RGB332 pixel classifier. Classes are mutually exclusive and
//   checked in priority order red, green, blue; anything else is NONE.
//   Ports:
//     i_px    [7:0]  RGB332 pixel {R[7:5], G[4:2], B[1:0]}
//     o_class [1:0]  class code (NONE/RED/GREEN/BLUE)
module px_classify
  import frame_color_pkg::*;
(
  input  logic [7:0] i_px,
  output color_e     o_class
);

  logic [2:0] w_r;
  logic [2:0] w_g;
  logic [1:0] w_b;

  assign w_r = i_px[R_MSB:R_LSB];
  assign w_g = i_px[G_MSB:G_LSB];
  assign w_b = i_px[B_MSB:B_LSB];

  always_comb begin
    o_class = CLR_NONE;
    if (w_r >= RG_HI_TH && w_g <= RG_LO_TH && w_b <= B_LO_TH)
      o_class = CLR_RED;
    else if (w_g >= RG_HI_TH && w_r <= RG_LO_TH && w_b <= B_LO_TH)
      o_class = CLR_GREEN;
    else if (w_b >= B_HI_TH && w_r <= RG_LO_TH && w_g <= RG_LO_TH)
      o_class = CLR_BLUE;
  end

endmodule

// File: rtl/frame_color_detect.sv
// frame_color_detect
//   Scans one stored RGB332 frame through a synchronous-read pixel buffer,
//   counts red/green/blue pixels and reports the dominant colour.
//   Ports:
//     i_clk, i_rst_n           clock, async active-low reset
//     i_start                  one-cycle scan request (honoured in IDLE only)
//     o_busy                   scan in progress
//     o_done                   one-cycle pulse, results valid
//     o_mem_rd_addr/_en        pixel buffer read port (address, enable)
//     i_mem_rd_data [7:0]      pixel, valid one cycle after the address
//     o_color [1:0]            00 none, 01 red, 10 green, 11 blue
//     o_red/green/blue_cnt     class counts of the last completed frame
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_IDLE   | waiting for i_start
//   ST_READ   | issuing addresses 0..NPIX-1, one per cycle
//   ST_DRAIN  | one cycle so the last read pixel gets counted
//   ST_DECIDE | latch counts and colour; done fires on the edge leaving
module frame_color_detect
  import frame_color_pkg::*;
#(
  parameter int AW      = 15,
  parameter int NPIX    = 19200,
  parameter int CW      = 15,
  parameter int MIN_CNT = 64
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic [AW-1:0] o_mem_rd_addr,
  output logic          o_mem_rd_en,
  input  logic [7:0]    i_mem_rd_data,
  output logic [1:0]    o_color,
  output logic [CW-1:0] o_red_cnt,
  output logic [CW-1:0] o_green_cnt,
  output logic [CW-1:0] o_blue_cnt
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  state_e        r_state;
  state_e        w_state_nxt;
  logic          w_accept;
  logic          w_last;
  logic          w_decide;

  logic [AW-1:0] r_addr;
  logic          r_rd_en;
  logic          r_busy;
  logic          r_done;
  logic          r_v;

  logic [CW-1:0] r_red_acc;
  logic [CW-1:0] r_grn_acc;
  logic [CW-1:0] r_blu_acc;
  logic [CW-1:0] r_red_cnt;
  logic [CW-1:0] r_grn_cnt;
  logic [CW-1:0] r_blu_cnt;
  color_e        r_color;

  color_e        w_class;
  color_e        w_color;
  logic [CW-1:0] w_win_cnt;

  px_classify u_px_classify (
    .i_px    (i_mem_rd_data),
    .o_class (w_class)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // done is registered on the DECIDE edge, so the FSM is already back in
  // IDLE while it is high; a start coincident with done must still be
  // ignored, hence the r_done gate on acceptance.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    w_decide    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start && !r_done) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        if (r_addr == LAST_ADDR) begin
          w_last      = 1'b1;
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN:  w_state_nxt = ST_DECIDE;
      ST_DECIDE: begin
        w_decide    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Dominant colour: later classes must be strictly larger to win a tie.
  always_comb begin
    w_win_cnt = r_red_acc;
    w_color   = CLR_RED;
    if (r_grn_acc > w_win_cnt) begin
      w_win_cnt = r_grn_acc;
      w_color   = CLR_GREEN;
    end
    if (r_blu_acc > w_win_cnt) begin
      w_win_cnt = r_blu_acc;
      w_color   = CLR_BLUE;
    end
    if (w_win_cnt < CW'(MIN_CNT))
      w_color = CLR_NONE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr  <= '0;
      r_rd_en <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_v     <= 1'b0;
    end else begin
      r_v    <= (r_state == ST_READ);
      r_done <= w_decide;
      if (w_accept) begin
        r_addr  <= '0;
        r_rd_en <= 1'b1;
        r_busy  <= 1'b1;
      end else if (w_last) begin
        r_rd_en <= 1'b0;
      end else if (r_state == ST_READ) begin
        r_addr  <= r_addr + AW'(1);
      end
      if (w_decide)
        r_busy <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_red_acc <= '0;
      r_grn_acc <= '0;
      r_blu_acc <= '0;
    end else if (w_accept) begin
      r_red_acc <= '0;
      r_grn_acc <= '0;
      r_blu_acc <= '0;
    end else if (r_v) begin
      case (w_class)
        CLR_RED:   r_red_acc <= r_red_acc + CW'(1);
        CLR_GREEN: r_grn_acc <= r_grn_acc + CW'(1);
        CLR_BLUE:  r_blu_acc <= r_blu_acc + CW'(1);
        default:   ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_red_cnt <= '0;
      r_grn_cnt <= '0;
      r_blu_cnt <= '0;
      r_color   <= CLR_NONE;
    end else if (w_decide) begin
      r_red_cnt <= r_red_acc;
      r_grn_cnt <= r_grn_acc;
      r_blu_cnt <= r_blu_acc;
      r_color   <= w_color;
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_mem_rd_addr = r_addr;
  assign o_mem_rd_en   = r_rd_en;
  assign o_color       = r_color;
  assign o_red_cnt     = r_red_cnt;
  assign o_green_cnt   = r_grn_cnt;
  assign o_blue_cnt    = r_blu_cnt;

endmodule

// File: tb/tb_frame_color_detect.sv
// tb_frame_color_detect
//   Two detector instances (MIN_CNT 2 and 8) share one 16-pixel frame buffer
//   image, each with its own synchronous read port. Results are compared
//   against a reference computed directly from the colour rules.
module tb_frame_color_detect;

  localparam int AW    = 5;
  localparam int CW    = 5;
  localparam int NPIX  = 16;
  localparam int MIN_A = 2;
  localparam int MIN_B = 8;

  logic          clk;
  logic          rst_n;
  logic          start;

  logic          busy_a, done_a, en_a;
  logic [AW-1:0] addr_a;
  logic [7:0]    rd_a;
  logic [1:0]    color_a;
  logic [CW-1:0] rc_a, gc_a, bc_a;

  logic          busy_b, done_b, en_b;
  logic [AW-1:0] addr_b;
  logic [7:0]    rd_b;
  logic [1:0]    color_b;
  logic [CW-1:0] rc_b, gc_b, bc_b;

  logic [7:0]    ram [32];

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt = 0;

  frame_color_detect #(.AW(AW), .NPIX(NPIX), .CW(CW), .MIN_CNT(MIN_A)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .o_busy(busy_a), .o_done(done_a),
    .o_mem_rd_addr(addr_a), .o_mem_rd_en(en_a), .i_mem_rd_data(rd_a),
    .o_color(color_a), .o_red_cnt(rc_a), .o_green_cnt(gc_a), .o_blue_cnt(bc_a)
  );

  frame_color_detect #(.AW(AW), .NPIX(NPIX), .CW(CW), .MIN_CNT(MIN_B)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .o_busy(busy_b), .o_done(done_b),
    .o_mem_rd_addr(addr_b), .o_mem_rd_en(en_b), .i_mem_rd_data(rd_b),
    .o_color(color_b), .o_red_cnt(rc_b), .o_green_cnt(gc_b), .o_blue_cnt(bc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (en_a) rd_a <= ram[addr_a];
    if (en_b) rd_b <= ram[addr_b];
  end

  always @(negedge clk) if (done_a) done_cnt++;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: classify each pixel from its decimal channel values.
  task automatic model(input int min_cnt, output int r, output int g, output int b, output int c);
    int rr, gg, bb, best;
    r = 0; g = 0; b = 0;
    for (int i = 0; i < NPIX; i++) begin
      rr = int'(ram[i]) / 32;
      gg = (int'(ram[i]) / 4) % 8;
      bb = int'(ram[i]) % 4;
      if (rr >= 4 && gg <= 3 && bb <= 1)      r++;
      else if (gg >= 4 && rr <= 3 && bb <= 1) g++;
      else if (bb >= 2 && rr <= 3 && gg <= 3) b++;
    end
    best = r; c = 1;
    if (g > best) begin best = g; c = 2; end
    if (b > best) begin best = b; c = 3; end
    if (best < min_cnt) c = 0;
  endtask

  task automatic check_results(input string tag);
    int r, g, b, c;
    model(MIN_A, r, g, b, c);
    chk({tag, "_red_a"},   int'(rc_a),    r);
    chk({tag, "_green_a"}, int'(gc_a),    g);
    chk({tag, "_blue_a"},  int'(bc_a),    b);
    chk({tag, "_color_a"}, int'(color_a), c);
    model(MIN_B, r, g, b, c);
    chk({tag, "_red_b"},   int'(rc_b),    r);
    chk({tag, "_green_b"}, int'(gc_b),    g);
    chk({tag, "_blue_b"},  int'(bc_b),    b);
    chk({tag, "_color_b"}, int'(color_b), c);
  endtask

  // mode 0: clean scan, 1: extra start pulses, 2: reset abort at scan cycle 8
  task automatic scan(input string tag, input int mode);
    int lat;
    int base;
    lat  = -1;
    base = done_cnt;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_acc_addr"}, int'(addr_a), 0);
    chk({tag, "_acc_en"},   int'(en_a),   1);
    chk({tag, "_acc_busy"}, int'(busy_a), 1);
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      @(negedge clk);
      start = (mode == 1 && k == 5);
      if (mode == 2 && k == 8) begin
        rst_n = 1'b0;
        #1;
        chk({tag, "_rst_busy"}, int'(busy_a), 0);
        chk({tag, "_rst_en"},   int'(en_a),   0);
        chk({tag, "_rst_addr"}, int'(addr_a), 0);
      end
      if (mode == 2 && k == 9) rst_n = 1'b1;
      @(posedge clk); #1;
      if (mode != 2 && k < NPIX) begin
        chk({tag, "_addr"}, int'(addr_a), k);
        chk({tag, "_en"},   int'(en_a),   1);
      end
      if (mode != 2 && k == NPIX) begin
        chk({tag, "_en_off"},    int'(en_a),   0);
        chk({tag, "_addr_hold"}, int'(addr_a), NPIX - 1);
      end
      if (done_a) begin
        lat = k;
        chk({tag, "_busy_at_done"}, int'(busy_a), 0);
        chk({tag, "_done_b"},       int'(done_b), 1);
      end
    end
    start = 1'b0;
    if (mode == 2) begin
      chk({tag, "_abort_no_done"}, done_cnt - base, 0);
      chk({tag, "_abort_busy"},    int'(busy_a),    0);
      return;
    end
    chk({tag, "_latency"}, lat, NPIX + 2);
    if (mode == 1) begin
      @(negedge clk); start = 1'b1;     // done is still high in this cycle
      @(posedge clk); #1;
      chk({tag, "_start_at_done_busy"}, int'(busy_a), 0);
      chk({tag, "_start_at_done_en"},   int'(en_a),   0);
      @(negedge clk); start = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_one_done"}, done_cnt - base, 1);
    check_results(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 32; i++) ram[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  int'(busy_a),  0);
    chk("rst_done",  int'(done_a),  0);
    chk("rst_en",    int'(en_a),    0);
    chk("rst_color", int'(color_a), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_busy",  int'(busy_a), 0);
    chk("idle_done",  int'(done_a), 0);
    chk("idle_en",    int'(en_a),   0);
    chk("idle_addr",  int'(addr_a), 0);
    chk("idle_color", int'(color_b), 0);
    chk("idle_red",   int'(rc_a),   0);
    chk("idle_green", int'(gc_b),   0);
    chk("idle_blue",  int'(bc_a),   0);

    // pure red
    for (int i = 0; i < NPIX; i++) ram[i] = 8'hE0;
    scan("red", 0);
    chk("red_fixed_cnt",   int'(rc_a),    16);
    chk("red_fixed_color", int'(color_a), 1);

    // green/blue tie at 5, six white
    for (int i = 0; i < NPIX; i++)
      ram[i] = (i < 5) ? 8'h1C : (i < 10) ? 8'h03 : 8'hFF;
    scan("tie", 0);
    chk("tie_fixed_color", int'(color_a), 2);
    chk("tie_fixed_blue",  int'(bc_a),    5);
    chk("tie_fixed_red",   int'(rc_a),    0);

    // seven red, below MIN_CNT of instance b
    for (int i = 0; i < NPIX; i++) ram[i] = (i < 7) ? 8'hE0 : 8'h00;
    scan("low", 0);
    chk("low_fixed_red_b",   int'(rc_b),    7);
    chk("low_fixed_color_b", int'(color_b), 0);

    // extra start pulses mid-scan and coincident with done
    for (int i = 0; i < NPIX; i++) ram[i] = (i % 3 == 0) ? 8'h03 : 8'h1C;
    scan("pulse", 1);

    // reset abort, then a clean rerun of a different frame
    for (int i = 0; i < NPIX; i++) ram[i] = (i < 9) ? 8'h02 : 8'hE1;
    scan("abort", 2);
    chk("abort_cnt_cleared", int'(gc_a), 0);
    scan("rerun", 0);

    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < NPIX; i++) begin
        case ($urandom_range(0, 4))
          0:       ram[i] = 8'hE0 | 8'($urandom_range(0, 1));
          1:       ram[i] = 8'h1C;
          2:       ram[i] = 8'h02 | 8'($urandom_range(0, 1));
          default: ram[i] = 8'($urandom);
        endcase
      end
      scan($sformatf("rnd%0d", f), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
